// File: rtl/alu_decode.sv
// RV32I decode stage: one registered valid/ready slot between fetch and execute.
// Optional ILLEGAL_INSTR_TRAP_EN drives out_illegal; otherwise illegal words pass as NOP bundles.
module alu_decode #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      funct_alu,
   output logic [1:0]      sel_in1,
   output logic            sel_in2,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            reg_we,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal,
   output logic            dbg_state
);

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JLR = 7'b1100111;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            r_state;
   logic [3:0]        r_funct;
   logic [1:0]        r_sel_in1;
   logic              r_sel_in2;
   logic [XLEN-1:0]   r_imm;
   logic [4:0]        r_rs1, r_rs2, r_rd;
   logic              r_we;
   logic [XLEN-1:0]   r_pc;

   logic [6:0]        w_opcode;
   logic [2:0]        w_f3;
   logic [6:0]        w_f7;
   logic [3:0]        w_funct;
   logic [1:0]        w_sel_in1;
   logic              w_sel_in2;
   logic [31:0]       w_imm32;
   logic [XLEN-1:0]   w_imm;
   logic              w_we;
   logic              w_illegal;
   logic              w_in_ready;

   assign w_opcode = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];

   always_comb begin
      w_funct   = 4'b0000;
      w_sel_in1 = 2'b00;
      w_sel_in2 = 1'b1;
      w_imm32   = 32'd0;
      w_we      = 1'b0;
      w_illegal = 1'b0;
      case (w_opcode)
         OP_REG: begin
            w_funct   = {in_instr[30], w_f3};
            w_sel_in2 = 1'b0;
            w_we      = 1'b1;
            if (!((w_f7 == 7'b0000000) ||
                  (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
               w_illegal = 1'b1;
            if (w_f3 == 3'b010 || w_f3 == 3'b011)
               w_illegal = 1'b1;
         end
         OP_IMM: begin
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            w_we    = 1'b1;
            // Only shifts carry an op qualifier in bit 30; other I-ops use it as immediate.
            w_funct = (w_f3 == 3'b101) ? {in_instr[30], 3'b101} : {1'b0, w_f3};
            if (w_f3 == 3'b001 && w_f7 != 7'b0000000)
               w_illegal = 1'b1;
            if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
               w_illegal = 1'b1;
            if (w_f3 == 3'b010 || w_f3 == 3'b011)
               w_illegal = 1'b1;
         end
         OP_LUI: begin
            w_sel_in1 = 2'b10;
            w_imm32   = {in_instr[31:12], 12'd0};
            w_we      = 1'b1;
         end
         OP_AUI: begin
            w_sel_in1 = 2'b01;
            w_imm32   = {in_instr[31:12], 12'd0};
            w_we      = 1'b1;
         end
         OP_LD: begin
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            w_we    = 1'b1;
         end
         OP_ST: begin
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_JAL: begin
            w_sel_in1 = 2'b01;
            w_imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
            w_we      = 1'b1;
         end
         OP_JLR: begin
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            w_we    = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      if (w_illegal) begin
         w_funct   = 4'b0000;
         w_sel_in1 = 2'b00;
         w_sel_in2 = 1'b1;
         w_imm32   = 32'd0;
         w_we      = 1'b0;
      end
      if (in_instr[11:7] == 5'd0)
         w_we = 1'b0;
   end

   assign w_imm = XLEN'($signed(w_imm32));

   // Handshake: a beat moves when valid && ready on the same rising edge; a held
   // bundle never changes while out_valid && !out_ready; flush beats an accept.
   assign w_in_ready = (r_state == EMPTY) || out_ready;

`ifdef ILLEGAL_INSTR_TRAP_EN
   logic r_illegal;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= EMPTY;
         r_funct   <= 4'd0;
         r_sel_in1 <= 2'd0;
         r_sel_in2 <= 1'b0;
         r_imm     <= '0;
         r_rs1     <= 5'd0;
         r_rs2     <= 5'd0;
         r_rd      <= 5'd0;
         r_we      <= 1'b0;
         r_pc      <= '0;
`ifdef ILLEGAL_INSTR_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else if (flush) begin
         r_state <= EMPTY;
      end else if (in_valid && w_in_ready) begin
         r_state   <= FULL;
         r_funct   <= w_funct;
         r_sel_in1 <= w_sel_in1;
         r_sel_in2 <= w_sel_in2;
         r_imm     <= w_imm;
         r_rs1     <= in_instr[19:15];
         r_rs2     <= in_instr[24:20];
         r_rd      <= in_instr[11:7];
         r_we      <= w_we;
         r_pc      <= in_pc;
`ifdef ILLEGAL_INSTR_TRAP_EN
         r_illegal <= w_illegal;
`endif
      end else if (out_ready) begin
         r_state <= EMPTY;
      end
   end

`ifdef ILLEGAL_INSTR_TRAP_EN
   assign out_illegal = r_illegal;
`else
   assign out_illegal = 1'b0;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == FULL);
   assign dbg_state = r_state;
   assign funct_alu = r_funct;
   assign sel_in1   = r_sel_in1;
   assign sel_in2   = r_sel_in2;
   assign imm       = r_imm;
   assign rs1       = r_rs1;
   assign rs2       = r_rs2;
   assign rd        = r_rd;
   assign reg_we    = r_we;
   assign out_pc    = r_pc;

endmodule

// File: tb/tb_alu_decode.sv
// Directed bench for alu_decode: decode table, back-to-back flow, stall, flush, async reset.
// Illegal-flag expectation follows ILLEGAL_INSTR_TRAP_EN.
module tb_alu_decode;

   localparam int W = 88;

`ifdef ILLEGAL_INSTR_TRAP_EN
   localparam logic EXP_ILL = 1'b1;
`else
   localparam logic EXP_ILL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, imm, out_pc;
   logic [3:0]  funct_alu;
   logic [1:0]  sel_in1;
   logic        sel_in2, reg_we, out_illegal, dbg_state;
   logic [4:0]  rs1, rs2, rd;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] w_obs;

   alu_decode #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .funct_alu(funct_alu), .sel_in1(sel_in1), .sel_in2(sel_in2), .imm(imm),
      .rs1(rs1), .rs2(rs2), .rd(rd), .reg_we(reg_we), .out_pc(out_pc),
      .out_illegal(out_illegal), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   assign w_obs = {funct_alu, sel_in1, sel_in2, imm, rs1, rs2, rd, reg_we, out_pc, out_illegal};

   function automatic logic [W-1:0] bun(input logic [3:0] f, input logic [1:0] s1,
                                        input logic s2, input logic [31:0] im,
                                        input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] d, input logic we,
                                        input logic [31:0] pc, input logic il);
      return {f, s1, s2, im, a, b, d, we, pc, il};
   endfunction

   function automatic logic [W-1:0] ill_bun(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] d, input logic [31:0] pc);
      return bun(4'h0, 2'b00, 1'b1, 32'h0, a, b, d, 1'b0, pc, EXP_ILL);
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [W-1:0] e);
      int t;
      exp_q.push_back(e);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      t = 0;
      while (!in_ready && t < 20) begin
         step();
         t++;
      end
      if (t >= 20) begin
         n_cmp++;
         n_err++;
         $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high pc=%h", pc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag);
      int t;
      t = 0;
      while (!out_valid && t < 10) begin
         step();
         t++;
      end
      chk({tag, "_valid"}, W'(out_valid), W'(1'b1));
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s observed=bundle expected=empty_queue", tag);
      end else begin
         chk(tag, w_obs, exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = 32'h0; in_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", W'(out_valid), W'(1'b0));
      chk("rst_ready", W'(in_ready), W'(1'b1));
      chk("rst_bundle", w_obs, '0);
      rst_n = 1'b1;
      step();

      send(32'h002081B3, 32'h100, bun(4'h0, 2'b00, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h100, 1'b0));
      chk("add_latency", W'(out_valid), W'(1'b1));
      expect_out("add");
      send(32'h407302B3, 32'h104, bun(4'h8, 2'b00, 1'b0, 32'h0, 5'd6, 5'd7, 5'd5, 1'b1, 32'h104, 1'b0));
      expect_out("sub");
      send(32'h4040D093, 32'h108, bun(4'hD, 2'b00, 1'b1, 32'h404, 5'd1, 5'd4, 5'd1, 1'b1, 32'h108, 1'b0));
      expect_out("srai");
      send(32'hFFF00093, 32'h10C, bun(4'h0, 2'b00, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 1'b1, 32'h10C, 1'b0));
      expect_out("addi_neg");
      send(32'h12345037, 32'h110, bun(4'h0, 2'b10, 1'b1, 32'h12345000, 5'd8, 5'd3, 5'd0, 1'b0, 32'h110, 1'b0));
      expect_out("lui_rd0");
      send(32'h4000E113, 32'h114, bun(4'h6, 2'b00, 1'b1, 32'h400, 5'd1, 5'd0, 5'd2, 1'b1, 32'h114, 1'b0));
      expect_out("ori_bit30");
      send(32'hFE20AE23, 32'h118, bun(4'h0, 2'b00, 1'b1, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd28, 1'b0, 32'h118, 1'b0));
      expect_out("sw_neg");
      send(32'hFFF1A203, 32'h11C, bun(4'h0, 2'b00, 1'b1, 32'hFFFFFFFF, 5'd3, 5'd31, 5'd4, 1'b1, 32'h11C, 1'b0));
      expect_out("lw");
      send(32'h001000EF, 32'h120, bun(4'h0, 2'b01, 1'b1, 32'h800, 5'd0, 5'd1, 5'd1, 1'b1, 32'h120, 1'b0));
      expect_out("jal_pos");
      send(32'hFFDFF06F, 32'h124, bun(4'h0, 2'b01, 1'b1, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd0, 1'b0, 32'h124, 1'b0));
      expect_out("jal_neg");
      send(32'hFFFFF297, 32'h128, bun(4'h0, 2'b01, 1'b1, 32'hFFFFF000, 5'd31, 5'd31, 5'd5, 1'b1, 32'h128, 1'b0));
      expect_out("auipc");
      send(32'h010280E7, 32'h12C, bun(4'h0, 2'b00, 1'b1, 32'h10, 5'd5, 5'd16, 5'd1, 1'b1, 32'h12C, 1'b0));
      expect_out("jalr");
      send(32'h0020A1B3, 32'h130, ill_bun(5'd1, 5'd2, 5'd3, 32'h130));
      expect_out("slt_illegal");
      send(32'h4020C1B3, 32'h134, ill_bun(5'd1, 5'd2, 5'd3, 32'h134));
      expect_out("xor_f7_illegal");
      send(32'h40109093, 32'h138, ill_bun(5'd1, 5'd1, 5'd1, 32'h138));
      expect_out("slli_f7_illegal");
      send(32'h0000007F, 32'h13C, ill_bun(5'd0, 5'd0, 5'd0, 32'h13C));
      expect_out("bad_opcode");
      step();
      chk("drain_empty", W'(out_valid), W'(1'b0));

      // Stall: held bundle must not move while a new word waits.
      send(32'h407302B3, 32'h200, bun(4'h8, 2'b00, 1'b0, 32'h0, 5'd6, 5'd7, 5'd5, 1'b1, 32'h200, 1'b0));
      out_ready = 1'b0;
      exp_q.push_back(bun(4'h0, 2'b00, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 1'b1, 32'h204, 1'b0));
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h204;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", W'(in_ready), W'(1'b0));
         chk("stall_valid", W'(out_valid), W'(1'b1));
         chk("stall_bundle", w_obs, exp_q[0]);
         step();
      end
      chk("stall_bundle_end", w_obs, exp_q.pop_front());
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", W'(in_ready), W'(1'b1));
      step();
      in_valid = 1'b0;
      expect_out("stall_next");

      // Flush beats an accept that would otherwise happen.
      send(32'h002081B3, 32'h300, bun(4'h0, 2'b00, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h300, 1'b0));
      expect_out("pre_flush");
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h304;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_accept", W'(out_valid), W'(1'b0));
      step();
      chk("flush_stays_empty", W'(out_valid), W'(1'b0));

      // Flush kills a stalled bundle.
      send(32'h002081B3, 32'h310, bun(4'h0, 2'b00, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h310, 1'b0));
      expect_out("pre_flush_stall");
      out_ready = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_stalled", W'(out_valid), W'(1'b0));
      out_ready = 1'b1;

      // Asynchronous reset while FULL and stalled.
      send(32'h12345037, 32'h400, bun(4'h0, 2'b10, 1'b1, 32'h12345000, 5'd8, 5'd3, 5'd0, 1'b0, 32'h400, 1'b0));
      expect_out("pre_reset");
      out_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", W'(out_valid), W'(1'b0));
      chk("async_rst_ready", W'(in_ready), W'(1'b1));
      chk("async_rst_bundle", w_obs, '0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      send(32'h407302B3, 32'h500, bun(4'h8, 2'b00, 1'b0, 32'h0, 5'd6, 5'd7, 5'd5, 1'b1, 32'h500, 1'b0));
      expect_out("post_reset");
      chk("queue_empty", W'(exp_q.size()), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
